// File: rtl/uart_core.sv
// rtl/uart_core.sv - UART transmitter and receiver; parity bit enabled by macro UART_PARITY_EN
module uart_core #(
  parameter int CLKS_PER_BIT = 40000,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] i_tx_byte,
  input  logic                 i_tx_dv,
  output logic                 o_tx_ready,
  output logic                 o_tx_active,
  output logic                 o_tx_done,
  output logic                 o_tx_serial,
  input  logic                 i_rx_serial,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_rx_dv,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_parity_err
);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP, RX_WAIT_IDLE
  } rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [15:0]          tx_cnt, tx_cnt_n;
  logic [2:0]           tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_data, tx_data_n;
  logic                 tx_bit_end;

  assign tx_bit_end  = (tx_cnt == BIT_LAST);
  assign o_tx_ready  = (tx_state == TX_IDLE);
  assign o_tx_active = ~o_tx_ready;

  // Line level for a given state; used on the next-state values so the pin is a flop.
  function automatic logic tx_level(input tx_state_t st, input logic [DATA_BITS-1:0] d,
                                    input logic [2:0] idx);
    case (st)
      TX_START:  tx_level = 1'b0;
      TX_DATA:   tx_level = d[idx];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_level = ^d ^ PARITY_ODD[0];
`endif
      default:   tx_level = 1'b1;
    endcase
  endfunction

  // TX next state: bit timing, data index and stop-bit count.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_data_n  = tx_data;
    o_tx_done  = 1'b0;
    if (tx_state != TX_IDLE) tx_cnt_n = tx_bit_end ? 16'd0 : tx_cnt + 16'd1;
    case (tx_state)
      TX_IDLE: if (i_tx_dv) begin
        tx_data_n  = i_tx_byte;
        tx_cnt_n   = 16'd0;
        tx_state_n = TX_START;
      end
      TX_START: if (tx_bit_end) begin
        tx_idx_n   = 3'd0;
        tx_state_n = TX_DATA;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_idx_n = tx_idx + 3'd1;
        if (tx_idx == DATA_LAST) begin
          tx_idx_n = 3'd0;
`ifdef UART_PARITY_EN
          tx_state_n = TX_PARITY;
`else
          tx_state_n = TX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_bit_end) tx_state_n = TX_STOP;
`endif
      TX_STOP: if (tx_bit_end) begin
        if (tx_idx == STOP_LAST) begin
          o_tx_done  = 1'b1;
          tx_idx_n   = 3'd0;
          tx_state_n = TX_IDLE;
        end else begin
          tx_idx_n = tx_idx + 3'd1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // TX state register and registered serial output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= 16'd0;
      tx_idx      <= 3'd0;
      tx_data     <= '0;
      o_tx_serial <= 1'b1;
    end else begin
      tx_state    <= tx_state_n;
      tx_cnt      <= tx_cnt_n;
      tx_idx      <= tx_idx_n;
      tx_data     <= tx_data_n;
      o_tx_serial <= tx_level(tx_state_n, tx_data_n, tx_idx_n);
    end
  end

  // ---------------- receiver ----------------
  logic [1:0]           rx_sync;
  logic                 rx_prev, rx_s, rx_sample;
  rx_state_t            rx_state, rx_state_n;
  logic [15:0]          rx_cnt, rx_cnt_n;
  logic [2:0]           rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n, rx_byte_n;
  logic                 rx_dv_n, rx_ferr_n;
`ifdef UART_PARITY_EN
  logic                 rx_par, rx_par_n, rx_perr, rx_perr_n;
  assign o_rx_parity_err = rx_perr;
`else
  assign o_rx_parity_err = 1'b0 & PARITY_ODD[0];
`endif

  assign rx_s      = rx_sync[1];
  assign rx_sample = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

  // Two-flop synchroniser plus a history flop for start-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], i_rx_serial};
      rx_prev <= rx_s;
    end
  end

  // RX next state: start validation, bit sampling, stop check and break wait.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_byte_n  = o_rx_byte;
    rx_dv_n    = 1'b0;
    rx_ferr_n  = o_rx_frame_err;
`ifdef UART_PARITY_EN
    rx_par_n   = rx_par;
    rx_perr_n  = rx_perr;
`endif
    if (rx_state != RX_IDLE && rx_state != RX_WAIT_IDLE)
      rx_cnt_n = rx_sample ? 16'd0 : rx_cnt + 16'd1;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_s) begin
        rx_cnt_n   = 16'd0;
        rx_state_n = RX_START;
      end
      RX_START: if (rx_sample) begin
        rx_idx_n   = 3'd0;
        rx_state_n = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_sample) begin
        rx_shift_n[rx_idx] = rx_s;
        rx_idx_n = rx_idx + 3'd1;
        if (rx_idx == DATA_LAST) begin
`ifdef UART_PARITY_EN
          rx_state_n = RX_PARITY;
`else
          rx_state_n = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_sample) begin
        rx_par_n   = rx_s;
        rx_state_n = RX_STOP;
      end
`endif
      RX_STOP: if (rx_sample) begin
        rx_dv_n    = 1'b1;
        rx_byte_n  = rx_shift;
        rx_ferr_n  = ~rx_s;
`ifdef UART_PARITY_EN
        rx_perr_n  = rx_par ^ (^rx_shift) ^ PARITY_ODD[0];
`endif
        rx_state_n = rx_s ? RX_IDLE : RX_WAIT_IDLE;
      end
      RX_WAIT_IDLE: if (rx_s) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX state register and held result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state       <= RX_IDLE;
      rx_cnt         <= 16'd0;
      rx_idx         <= 3'd0;
      rx_shift       <= '0;
      o_rx_byte      <= '0;
      o_rx_dv        <= 1'b0;
      o_rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par         <= 1'b0;
      rx_perr        <= 1'b0;
`endif
    end else begin
      rx_state       <= rx_state_n;
      rx_cnt         <= rx_cnt_n;
      rx_idx         <= rx_idx_n;
      rx_shift       <= rx_shift_n;
      o_rx_byte      <= rx_byte_n;
      o_rx_dv        <= rx_dv_n;
      o_rx_frame_err <= rx_ferr_n;
`ifdef UART_PARITY_EN
      rx_par         <= rx_par_n;
      rx_perr        <= rx_perr_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - scoreboard bench for uart_core with randomized frames
`timescale 1ns/1ps
module tb_uart_core;
  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FBITS = 10 + PB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_tx_byte = 8'h00;
  logic       i_tx_dv = 1'b0;
  logic       o_tx_ready, o_tx_active, o_tx_done, o_tx_serial;
  logic       rx_line;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic [7:0] o_rx_byte;
  logic       o_rx_dv, o_rx_frame_err, o_rx_parity_err;

  assign rx_line = loop ? o_tx_serial : rx_drv;

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .i_tx_byte(i_tx_byte), .i_tx_dv(i_tx_dv),
    .o_tx_ready(o_tx_ready), .o_tx_active(o_tx_active), .o_tx_done(o_tx_done),
    .o_tx_serial(o_tx_serial), .i_rx_serial(rx_line), .o_rx_byte(o_rx_byte),
    .o_rx_dv(o_rx_dv), .o_rx_frame_err(o_rx_frame_err), .o_rx_parity_err(o_rx_parity_err)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  bit         mon_tx_en = 1'b1;
  logic [7:0] tx_exp[$];
  logic [9:0] rx_exp[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame bit idx of a byte (start, LSB-first data, even parity, stop).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PB == 1 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  always @(negedge clk) if (o_tx_done) done_cnt++;

  // RX scoreboard: every o_rx_dv must match the oldest expected frame.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && o_rx_dv) begin
      if (rx_exp.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_unexpected: got dv with byte %02h, none expected", o_rx_byte);
      end else begin
        e = rx_exp.pop_front();
        check("rx_byte", o_rx_byte, e[7:0]);
        check("rx_frame_err", o_rx_frame_err, e[8]);
        check("rx_parity_err", o_rx_parity_err, e[9]);
      end
    end
  end

  // TX scoreboard: decode the serial line at bit centres and compare with the queue.
  initial begin : tx_mon
    logic       prev, st, sb, pb;
    logic [7:0] got, e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !o_tx_serial && mon_tx_en) begin
        @(negedge clk);
        st = o_tx_serial;
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(negedge clk);
          got[j] = o_tx_serial;
        end
        pb = 1'b0;
        if (PB == 1) begin
          repeat (CPB) @(negedge clk);
          pb = o_tx_serial;
        end
        repeat (CPB) @(negedge clk);
        sb = o_tx_serial;
        if (tx_exp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: decoded %02h, none expected", got);
        end else begin
          e = tx_exp.pop_front();
          check("tx_start_bit", st, 0);
          check("tx_byte", got, e);
          check("tx_stop_bit", sb, 1);
`ifdef UART_PARITY_EN
          check("tx_parity_bit", pb, ^e);
`endif
        end
      end
      prev = o_tx_serial;
    end
  end

  task automatic wait_tx_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!o_tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", o_tx_ready, 1);
  endtask

  task automatic tx_send(input logic [7:0] b, input bit hold, input bit to_rx);
    wait_tx_ready();
    i_tx_byte = b;
    i_tx_dv = 1'b1;
    tx_exp.push_back(b);
    if (to_rx) rx_exp.push_back({2'b00, b});
    @(posedge clk);
    #1;
    i_tx_byte = 8'($urandom);
    i_tx_dv = hold;
  endtask

  task automatic tx_exact(input logic [7:0] b);
    wait_tx_ready();
    i_tx_byte = b;
    i_tx_dv = 1'b1;
    tx_exp.push_back(b);
    for (int k = 0; k < FBITS * CPB; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) i_tx_dv = 1'b0;
      if (k == 10) begin i_tx_dv = 1'b1; i_tx_byte = ~b; end
      if (k == 12) begin i_tx_dv = 1'b0; i_tx_byte = b; end
      check("tx_line", o_tx_serial, frame_bit(b, k / CPB));
      check("tx_done", o_tx_done, (k == FBITS * CPB - 1));
      check("tx_ready_busy", o_tx_ready, 0);
      check("tx_active", o_tx_active, 1);
    end
    @(posedge clk);
    #1;
    check("tx_ready_after", o_tx_ready, 1);
    check("tx_done_after", o_tx_done, 0);
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk);
    rx_drv = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_v, input logic par_v);
    logic [9:0] e;
    e[7:0] = b;
    e[8]   = ~stop_v;
    e[9]   = (PB == 1) ? (par_v != ^b) : 1'b0;
    rx_exp.push_back(e);
    drive_bit(1'b0);
    for (int j = 0; j < 8; j++) drive_bit(b[j]);
    if (PB == 1) drive_bit(par_v);
    drive_bit(stop_v);
  endtask

  task automatic rx_good(input logic [7:0] b);
    rx_send(b, 1'b1, ^b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rx_exp.size() != 0 || tx_exp.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * CPB) @(negedge clk);
    check("rx_queue_empty", rx_exp.size(), 0);
    check("tx_queue_empty", tx_exp.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       stop_v, par_v;
    bit         hold;
    int         d0, hi;

    repeat (3) @(negedge clk);
    check("rst_tx_serial", o_tx_serial, 1);
    check("rst_tx_ready", o_tx_ready, 1);
    check("rst_tx_active", o_tx_active, 0);
    check("rst_tx_done", o_tx_done, 0);
    check("rst_rx_dv", o_rx_dv, 0);
    check("rst_rx_byte", o_rx_byte, 0);
    check("rst_rx_frame_err", o_rx_frame_err, 0);
    check("rst_rx_parity_err", o_rx_parity_err, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    tx_exact(8'hA5);
    drain();

    loop = 1'b1;
    tx_send(8'h00, 1'b1, 1'b1);
    tx_send(8'hFF, 1'b1, 1'b1);
    tx_send(8'h3C, 1'b0, 1'b1);
    drain();
    loop = 1'b0;

    @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (12) @(negedge clk);
    rx_good(8'h55);
    drain();

    b = 8'h12;
    rx_send(b, 1'b0, ^b);
    repeat (40) @(negedge clk);
    rx_drv = 1'b1;
    repeat (8) @(negedge clk);
    rx_good(8'hC3);
    drain();

`ifdef UART_PARITY_EN
    rx_send(8'h07, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    rx_send(8'h07, 1'b1, 1'b1);
    drain();
`endif

    loop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      hold = (i != 7) && ($urandom_range(0, 1) == 1);
      tx_send(b, hold, 1'b1);
      if (!hold) repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain();
    loop = 1'b0;

    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      stop_v = ($urandom_range(0, 3) != 0);
      par_v = (^b) ^ ($urandom_range(0, 3) == 0);
      rx_send(b, stop_v, par_v);
      if (!stop_v) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        rx_drv = 1'b1;
      end
      repeat ($urandom_range(6, 12)) @(negedge clk);
    end
    rx_good(8'hE7);
    drain();

    wait_tx_ready();
    mon_tx_en = 1'b0;
    d0 = done_cnt;
    i_tx_byte = 8'h96;
    i_tx_dv = 1'b1;
    @(posedge clk);
    #1;
    i_tx_dv = 1'b0;
    repeat (4 * CPB) @(posedge clk);
    #1;
    check("tx_line_bit3", o_tx_serial, frame_bit(8'h96, 4));
    rst_n = 1'b0;
    #1;
    check("midrst_tx_serial", o_tx_serial, 1);
    check("midrst_tx_ready", o_tx_ready, 1);
    check("midrst_tx_active", o_tx_active, 0);
    check("midrst_tx_done", o_tx_done, 0);
    check("midrst_rx_byte", o_rx_byte, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 12 * CPB; i++) begin
      @(negedge clk);
      if (o_tx_serial && o_tx_ready) hi++;
    end
    check("midrst_line_idle", hi, 12 * CPB);
    check("midrst_no_done", done_cnt, d0);
    mon_tx_en = 1'b1;

    loop = 1'b1;
    tx_send(8'h5A, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 40000, giving clk cycles per bit (12 MHz / 300 baud); legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter STOP_BITS, default 1, giving TX stop bits; legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, where 0 means even parity and 1 means odd parity (used only with UART_PARITY_EN).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_tx_byte, input, DATA_BITS bits: byte to transmit.
REQ-008 SHALL have port i_tx_dv, input, 1 bit: transmit request, sampled only while o_tx_ready=1.
REQ-009 SHALL have port o_tx_ready, output, 1 bit: transmitter idle and able to accept a byte.
REQ-010 SHALL have port o_tx_active, output, 1 bit: a frame is on the line.
REQ-011 SHALL have port o_tx_done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-012 SHALL have port o_tx_serial, output, 1 bit: serial line out, idle high.
REQ-013 SHALL have port i_rx_serial, input, 1 bit: asynchronous serial line in.
REQ-014 SHALL have port o_rx_byte, output, DATA_BITS bits: last received byte.
REQ-015 SHALL have port o_rx_dv, output, 1 bit: one-cycle pulse when o_rx_byte and the error flags are valid.
REQ-016 SHALL have port o_rx_frame_err, output, 1 bit: stop bit sampled low; valid with o_rx_dv.
REQ-017 SHALL have port o_rx_parity_err, output, 1 bit: parity mismatch; valid with o_rx_dv.

Function
REQ-018 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; each state holds the line for CLKS_PER_BIT cycles per bit; data is sent LSB first.
REQ-019 i_tx_dv=1 with o_tx_ready=1 SHALL latch i_tx_byte, drop o_tx_ready, and drive o_tx_serial low on the next cycle (1-cycle latency).
REQ-020 i_tx_dv while o_tx_ready=0 SHALL be ignored; no queuing, and the frame in progress is unaffected.
REQ-021 o_tx_done SHALL pulse for 1 cycle on the last cycle of the final stop bit; o_tx_ready SHALL be 1 on the following cycle, allowing back-to-back frames with no extra idle bit.
REQ-022 RX SHALL pass i_rx_serial through a 2-flop synchroniser before any use.
REQ-023 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; IDLE->START on a synchronised high-to-low transition.
REQ-024 RX SHALL sample the start bit at CLKS_PER_BIT/2 (integer division); if it is high, the FSM SHALL return to IDLE with no o_rx_dv (glitch reject).
REQ-025 RX SHALL sample each subsequent bit CLKS_PER_BIT cycles after the previous sample.
REQ-026 At the stop-bit sample, RX SHALL pulse o_rx_dv, update o_rx_byte, and set the error flags, which hold until the next o_rx_dv.
REQ-027 The RX receiver SHALL check 1 stop bit regardless of STOP_BITS.
REQ-028 A stop bit sampled low SHALL set o_rx_frame_err=1 and move the FSM to WAIT_IDLE, which remains until the line is high for 1 cycle (break handling), then goes to IDLE.
REQ-029 TX and RX SHALL be fully independent; simultaneous activity (loopback included) SHALL be legal.

Reset
REQ-030 While rst_n=0 the outputs SHALL be: o_tx_serial=1, o_tx_ready=1, o_tx_active=0, o_tx_done=0, o_rx_dv=0, o_rx_byte=0, both error flags=0, both FSMs in IDLE, all counters=0, synchroniser flops=1.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, with no o_tx_done or o_rx_dv pulse.

Configuration
REQ-032 With macro UART_PARITY_EN defined, TX SHALL insert a parity bit after the data (even or odd per PARITY_ODD), RX SHALL sample and check it, and o_rx_parity_err SHALL report a mismatch.
REQ-033 Without UART_PARITY_EN, the PARITY states and the parity logic SHALL be absent, and o_rx_parity_err SHALL be tied to 0.

Verification (CLKS_PER_BIT=4, DATA_BITS=8)
REQ-034 TX 0xA5 -> o_tx_serial reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; o_tx_done pulses at cycle 40 after the accept edge.
REQ-035 Loop o_tx_serial to i_rx_serial; send 0x00, 0xFF, 0x3C back-to-back -> three o_rx_dv pulses with matching bytes and no errors.
REQ-036 RX low glitch of 1 cycle on the idle line -> no o_rx_dv; the following valid 0x55 frame is received correctly.
REQ-037 RX frame 0x12 with stop bit driven low, then line held low for 40 cycles -> o_rx_frame_err=1 with o_rx_dv; no further o_rx_dv until the line returns high.
REQ-038 With UART_PARITY_EN and PARITY_ODD=0, RX 0x07 sent with parity bit 0 -> o_rx_parity_err=1; the same frame with parity bit 1 -> o_rx_parity_err=0.
REQ-039 rst_n pulsed low at TX data bit 3 -> o_tx_serial=1 and o_tx_ready=1 immediately, with no o_tx_done pulse.
